bus_uart_io: RTL and testbench
==============================

# bus_uart_io

Buffered UART transmitter peripheral on the CPU's toggle-handshake I/O bus. It is the parametrised successor to the single-byte UART I/O slave and adds:

- a TX FIFO of configurable depth, so the CPU stalls only when the FIFO is full;
- an internal baud generator running on the bus clock;
- a readable status register;
- completion of unmapped accesses, so the bus never hangs.

It sits on the `BUS_IO` slot beside the memory slave.

## Interface
- `CLK_FREQ`, 27000000: bus clock frequency in Hz.
- `BAUD`, 115200: line rate in baud.
- `FIFO_DEPTH`, 16: TX FIFO entries; must be a power of two, ≥2.
- `BASE_ADDR`, 16'h0000: byte address of the DATA register. STATUS is at `BASE_ADDR+2`.

Ports:
- `clk`  in  1  bus clock; all logic is on the posedge.
- `reset`  in  1  synchronous, active-high.
- `addr`  in  16  byte address.
- `cmd`  in  2  00 read, 01 write, 10 read_b, 11 write_b.
- `run`  in  1  request toggle; a request is pending while `run != done`.
- `wr_data`  in  16  write data; only `[7:0]` is used.
- `rd_data`  out  16  read data, registered.
- `done`  out  1  completion toggle.
- `uart_txp`  out  1  serial TX line; idles high.
- `tx_idle`  out  1  high when the FIFO is empty and the shifter is idle.

## Operation
Bus handshake:
- The block samples a request at every posedge where `run != done` and it is not stalled.
- On acceptance, `done` toggles at that same edge, so the requester sees completion one cycle after `run` toggled.
- Only one request can be outstanding. `addr`, `cmd` and `wr_data` must be held stable until `done` matches `run`.

Write to DATA (`cmd` 01 or 11):
- Pushes `wr_data[7:0]` into the FIFO.
- If the FIFO is full, the request stalls: `done` does not toggle until an entry is free.
- A push and a pop in the same cycle are legal when the FIFO is full. The push is accepted in that cycle.

Write to STATUS: ignored, completes immediately.

Reads (`cmd` 00 or 10):
- DATA returns 16'h0000.
- STATUS returns `{count[7:0], 5'b0, tx_busy, fifo_full, fifo_empty}`. `count` is the number of FIFO entries, zero-extended.
- Read-byte (`cmd` 10) at an odd address returns `{8'h00, status[15:8]}`. At an even address it returns `{8'h00, status[7:0]}`.

Unmapped address: the access completes in one cycle. Reads return 16'h0000; writes are dropped.

Baud generator:
- `DIV = CLK_FREQ/BAUD`, integer-truncated; must be ≥2.
- The counter is `$clog2(DIV)` bits wide and counts `DIV-1` down to 0. It reloads at every bit boundary.

Transmitter FSM:
- States: `IDLE`, `START`, `DATA`, `PAR` (only with the parity macro), `STOP`.
- `IDLE` → `START` when the FIFO is non-empty. The FIFO pops on that transition, and the byte is latched into the shift register.
- `START` drives 0 for one bit.
- `DATA` shifts 8 bits out LSB first; a 3-bit index wraps 7→0 on exit.
- `STOP` drives 1 for one bit, then goes to `IDLE`. If the FIFO is non-empty, it goes directly to `START` instead, with no extra idle bit.
- `tx_busy` is 1 in every state except `IDLE`.

## Timing
Reset values:
- `done`=0, `rd_data`=0, `uart_txp`=1, `tx_idle`=1.
- FIFO empty, FSM in `IDLE`, baud counter at `DIV-1`.

Reset mid-frame:
- The line goes high at the next edge and the frame is abandoned.
- The FIFO is flushed.
- A request that was pending is dropped. If `run`=1 after reset, a new request is seen as pending and is serviced normally.

Latency and frame timing:
- Accepted access to done toggle: 1 cycle.
- DATA write to start bit on the line: 2 cycles when the FIFO was empty and the FSM was idle.
- Frame length: 10×`DIV` cycles, or 11×`DIV` with parity.

Status coherency:
- `count` reflects push/pop as of the previous edge.
- A STATUS read in the same cycle as a pop returns the pre-pop count.

## Configuration
- `BUS_UART_IO_PARITY_EN` defined: the `PAR` state is compiled in and inserts an even-parity bit (the XOR of the 8 data bits) between `DATA` and `STOP`.
- Undefined: 8N1, and no `PAR` state exists.

## Structure
- Shared package `bus_pkg`:
  - the `bus_cmd_t` enum (READ, WRITE, READ_B, WRITE_B);
  - status bit indices `ST_EMPTY`=0, `ST_FULL`=1, `ST_BUSY`=2, `ST_COUNT_LSB`=8.
- The memory slave and the CPU core import `bus_pkg` as well.
- One sub-module, `sync_fifo`:
  - parameters `WIDTH` and `DEPTH`;
  - ports `push`/`pop`, `full`/`empty`, `count`;
  - pointers one bit wider than the address, so full and empty are distinguished on wrap.

## Test plan
- Use `DIV`=4.
- Write_b 8'h41 to DATA, FIFO empty → `done` toggles after 1 cycle. The line carries 0, 1000_0010 (LSB first), 1, each bit 4 cycles. With parity, the parity bit is 0. `tx_idle` returns to 1.
- Write 17 bytes back-to-back with depth 16 → 16 are accepted at one per 2 cycles. The 17th stalls until the first frame's pop, then completes. Output order is preserved.
- Read_b STATUS at `BASE_ADDR+2` during the first frame with 3 bytes queued → `rd_data`=16'h0004 (busy=1). At `BASE_ADDR+3` → 16'h0003.
- Read, then write, to 16'h0100 (unmapped) → each completes in 1 cycle with `rd_data`=0, and the line stays high.
- Assert `reset` mid-`DATA` with 5 bytes queued → `uart_txp`=1 next cycle. STATUS then reads 16'h0001, and no further frames are sent.
- Queue 2 bytes → the two frames are contiguous: the second `START` immediately follows the first `STOP`.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU toggle-handshake I/O bus: command encoding
// and the status register layout used by I/O slaves.
package bus_pkg;

    typedef enum logic [1:0] {
        READ    = 2'b00,
        WRITE   = 2'b01,
        READ_B  = 2'b10,
        WRITE_B = 2'b11
    } bus_cmd_t;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_COUNT_LSB = 8;

    function automatic logic [15:0] pack_status(input logic [7:0] count,
                                                input logic       busy,
                                                input logic       full,
                                                input logic       empty);
        logic [15:0] s;
        s = '0;
        s[ST_COUNT_LSB +: 8] = count;
        s[ST_BUSY]           = busy;
        s[ST_FULL]           = full;
        s[ST_EMPTY]          = empty;
        return s;
    endfunction

endpackage

// File: rtl/bus_uart_io_if.sv
// Toggle-handshake I/O bus bundle; the CPU side is the master, peripherals
// such as bus_uart_io are slaves.
interface bus_uart_io_if;
    import bus_pkg::*;

    logic [15:0] addr;
    bus_cmd_t    cmd;
    logic        run;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        done;

    modport master (output addr, output cmd, output run, output wr_data,
                    input rd_data, input done);
    modport slave  (input addr, input cmd, input run, input wr_data,
                    output rd_data, output done);
endinterface

// File: rtl/bus_uart_io_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers so full and empty stay distinct
// on wrap; a push while full is taken when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/bus_uart_io.sv
// Buffered UART transmitter on the toggle-handshake I/O bus: DATA pushes into
// a TX FIFO, STATUS reports fill level. Define BUS_UART_IO_PARITY_EN for 8E1.
module bus_uart_io
    import bus_pkg::*;
#(
    parameter int          CLK_FREQ   = 27000000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
    input  logic           clk,
    input  logic           reset,
    bus_uart_io_if.slave   bus,
    output logic           uart_txp,
    output logic           tx_idle
);
    localparam int             DIV       = CLK_FREQ / BAUD;
    localparam int             CNT_W     = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0]    STAT_ADDR = BASE_ADDR + 16'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef BUS_UART_IO_PARITY_EN
        PAR,
`endif
        STOP
    } tx_state_t;

    tx_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        shift_q;
    logic [2:0]        idx_q;
    logic              uart_txp_q;
`ifdef BUS_UART_IO_PARITY_EN
    logic              par_q;
`endif

    logic              done_q, done_d;
    logic [15:0]       rd_data_q, rd_data_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_rdata;
    logic [CW-1:0]     fifo_count;
    logic              baud_tick, tx_busy;
    logic [15:0]       status;
    logic              pending, is_write, is_data, is_status, stall, accept;
    logic              unused_wr_hi;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (bus.wr_data[7:0]),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign baud_tick    = (cnt_q == '0);
    assign tx_busy      = (state_q != IDLE);
    assign fifo_pop     = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && baud_tick));
    assign status       = pack_status(8'(fifo_count), tx_busy, fifo_full, fifo_empty);
    assign unused_wr_hi = ^bus.wr_data[15:8];

    // A full FIFO only stalls a DATA write if the shifter is not freeing a slot this cycle.
    always_comb begin
        pending   = (bus.run != done_q);
        is_write  = (bus.cmd == WRITE) || (bus.cmd == WRITE_B);
        is_data   = (bus.addr[15:1] == BASE_ADDR[15:1]);
        is_status = (bus.addr[15:1] == STAT_ADDR[15:1]);
        stall     = is_write && is_data && fifo_full && !fifo_pop;
        accept    = pending && !stall;
        fifo_push = accept && is_write && is_data;
        done_d    = done_q ^ accept;
        rd_data_d = rd_data_q;
        if (accept && !is_write) begin
            rd_data_d = 16'h0000;
            if (is_status) begin
                if (bus.cmd == READ_B) begin
                    rd_data_d = bus.addr[0] ? {8'h00, status[15:8]} : {8'h00, status[7:0]};
                end else begin
                    rd_data_d = status;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q    <= 1'b0;
            rd_data_q <= 16'h0000;
        end else begin
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Any FIFO pop starts a new frame, which lets STOP chain into START with no idle bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_MAX;
            shift_q    <= 8'h00;
            idx_q      <= 3'd0;
            uart_txp_q <= 1'b1;
`ifdef BUS_UART_IO_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            cnt_q <= (state_q == IDLE || baud_tick) ? CNT_MAX : cnt_q - CNT_W'(1);
            unique case (state_q)
                IDLE: uart_txp_q <= 1'b1;
                START: if (baud_tick) begin
                    state_q    <= DATA;
                    uart_txp_q <= shift_q[0];
                    shift_q    <= shift_q >> 1;
                end
                DATA: if (baud_tick) begin
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef BUS_UART_IO_PARITY_EN
                        state_q    <= PAR;
                        uart_txp_q <= par_q;
`else
                        state_q    <= STOP;
                        uart_txp_q <= 1'b1;
`endif
                    end else begin
                        uart_txp_q <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                    end
                end
`ifdef BUS_UART_IO_PARITY_EN
                PAR: if (baud_tick) begin
                    state_q    <= STOP;
                    uart_txp_q <= 1'b1;
                end
`endif
                STOP: if (baud_tick) begin
                    state_q    <= IDLE;
                    uart_txp_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (fifo_pop) begin
                state_q    <= START;
                shift_q    <= fifo_rdata;
                cnt_q      <= CNT_MAX;
                uart_txp_q <= 1'b0;
`ifdef BUS_UART_IO_PARITY_EN
                par_q      <= ^fifo_rdata;
`endif
            end
        end
    end

    assign uart_txp    = uart_txp_q;
    assign tx_idle     = fifo_empty && !tx_busy;
    assign bus.done    = done_q;
    assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_bus_uart_io.sv
// Self-checking bench for bus_uart_io (DIV=4): a queue/frame-timer model
// predicts done, rd_data, uart_txp and tx_idle every cycle.
module tb_bus_uart_io;
    import bus_pkg::*;

    localparam int          CLK_FREQ = 400;
    localparam int          BAUD     = 100;
    localparam int          DIV      = 4;
    localparam int          DEPTH    = 16;
    localparam logic [15:0] BASE     = 16'h0000;
`ifdef BUS_UART_IO_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic clk = 1'b0;
    logic reset;
    logic uart_txp;
    logic tx_idle;

    bus_uart_io_if bus_if();

    bus_uart_io #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if),
        .uart_txp (uart_txp),
        .tx_idle  (tx_idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: byte queue plus a countdown over the current frame.
    logic [7:0]       mq[$];
    int               frame_left;
    logic [NBITS-1:0] fbits;
    logic             exp_done;
    logic [15:0]      exp_rd;
    int               m_sz;
    logic             m_pop, m_wr, m_isdata, m_isstat, m_acc;
    logic [15:0]      m_stat;

    function automatic logic [NBITS-1:0] frameBits(input logic [7:0] b);
        logic [NBITS-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef BUS_UART_IO_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    function automatic logic expLine();
        if (frame_left == 0) return 1'b1;
        return fbits[(FRAME - frame_left) / DIV];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            frame_left = 0;
            fbits      = '1;
            exp_done   = 1'b0;
            exp_rd     = 16'h0000;
        end else begin
            m_sz     = mq.size();
            m_pop    = (m_sz > 0) && (frame_left <= 1);
            m_stat   = {8'(m_sz), 5'b0, frame_left > 0, m_sz == DEPTH, m_sz == 0};
            m_wr     = (bus_if.cmd == WRITE) || (bus_if.cmd == WRITE_B);
            m_isdata = (bus_if.addr >> 1) == (BASE >> 1);
            m_isstat = (bus_if.addr >> 1) == ((BASE + 16'd2) >> 1);
            m_acc    = (bus_if.run != exp_done) && !(m_wr && m_isdata && m_sz == DEPTH && !m_pop);
            if (m_acc) begin
                exp_done = ~exp_done;
                if (!m_wr) begin
                    if (!m_isstat)                exp_rd = 16'h0000;
                    else if (bus_if.cmd == READ_B) exp_rd = bus_if.addr[0] ? {8'h00, m_stat[15:8]} : {8'h00, m_stat[7:0]};
                    else                          exp_rd = m_stat;
                end
            end
            if (m_pop) begin
                fbits      = frameBits(mq.pop_front());
                frame_left = FRAME;
            end else if (frame_left > 0) begin
                frame_left = frame_left - 1;
            end
            if (m_acc && m_wr && m_isdata) mq.push_back(bus_if.wr_data[7:0]);
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("done",     16'(bus_if.done), 16'(exp_done));
            checkOutput("rd_data",  bus_if.rd_data,   exp_rd);
            checkOutput("uart_txp", 16'(uart_txp),    16'(expLine()));
            checkOutput("tx_idle",  16'(tx_idle),     16'((mq.size() == 0) && (frame_left == 0)));
        end
    end

    task automatic waitDone(output int lat);
        lat = 0;
        while (bus_if.done !== bus_if.run && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        if (bus_if.done !== bus_if.run) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL handshake_timeout: done %b run %b", bus_if.done, bus_if.run);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input bus_cmd_t c, input logic [15:0] d, output int lat);
        @(negedge clk);
        bus_if.addr    = a;
        bus_if.cmd     = c;
        bus_if.wr_data = d;
        bus_if.run     = ~bus_if.run;
        waitDone(lat);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (tx_idle !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tx_idle !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL idle_timeout: tx_idle %b", tx_idle);
        end
    endtask

    task automatic doReset(input int cycles);
        int lat;
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        waitDone(lat);
    endtask

    initial begin
        int               lat;
        int               lat17;
        int               ok16;
        logic             rec[2*FRAME];
        logic [NBITS-1:0] lit41;
        logic [15:0]      ra;
        bus_cmd_t         rc;
        int               r;

`ifdef BUS_UART_IO_PARITY_EN
        lit41 = 11'b1_0_01000001_0;
`else
        lit41 = 10'b1_01000001_0;
`endif
        reset          = 1'b1;
        bus_if.run     = 1'b0;
        bus_if.addr    = 16'h0000;
        bus_if.cmd     = READ;
        bus_if.wr_data = 16'h0000;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        checkOutput("reset_done",    16'(bus_if.done), 16'h0000);
        checkOutput("reset_rd_data", bus_if.rd_data,   16'h0000);
        checkOutput("reset_txp",     16'(uart_txp),    16'h0001);
        checkOutput("reset_idle",    16'(tx_idle),     16'h0001);
        reset = 1'b0;

        // Single byte 0x41: 1-cycle handshake, start bit 2 cycles after the request.
        applyStimulus(BASE, WRITE_B, 16'h0041, lat);
        checkOutput("write_latency", 16'(lat), 16'd1);
        for (int j = 0; j < FRAME + 4; j++) begin
            @(negedge clk);
            rec[j] = uart_txp;
        end
        for (int k = 0; k < NBITS; k++) begin
            checkOutput($sformatf("frame41_bit%0d", k), 16'(rec[k*DIV + 1]), 16'(lit41[k]));
        end
        checkOutput("frame41_first", 16'(rec[0]), 16'h0000);
        checkOutput("frame41_after", 16'(rec[FRAME]), 16'h0001);
        waitIdle();
        checkOutput("idle_after_41", 16'(tx_idle), 16'h0001);

        // Status byte reads with a frame in flight and 3 bytes queued.
        applyStimulus(BASE, WRITE, 16'h00A5, lat);
        applyStimulus(BASE, WRITE, 16'h0011, lat);
        applyStimulus(BASE, WRITE, 16'h0022, lat);
        applyStimulus(BASE, WRITE, 16'h0033, lat);
        applyStimulus(BASE + 16'd2, READ_B, 16'h0000, lat);
        checkOutput("status_lo", bus_if.rd_data, 16'h0004);
        applyStimulus(BASE + 16'd3, READ_B, 16'h0000, lat);
        checkOutput("status_hi", bus_if.rd_data, 16'h0003);
        waitIdle();

        // Unmapped accesses complete at once and leave the line alone.
        applyStimulus(16'h0100, READ, 16'h0000, lat);
        checkOutput("unmapped_rd_lat", 16'(lat), 16'd1);
        checkOutput("unmapped_rd",     bus_if.rd_data, 16'h0000);
        applyStimulus(16'h0100, WRITE, 16'h00FF, lat);
        checkOutput("unmapped_wr_lat", 16'(lat), 16'd1);
        repeat (4) @(negedge clk);
        checkOutput("unmapped_wr_line", 16'(uart_txp), 16'h0001);
        checkOutput("unmapped_wr_idle", 16'(tx_idle),  16'h0001);

        // Frame in flight, then 17 writes: 16 fill the FIFO, the 17th waits for a pop.
        applyStimulus(BASE, WRITE, 16'h0080, lat);
        ok16 = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(BASE, WRITE_B, 16'($urandom_range(0, 255)), lat);
            if (lat == 1) ok16++;
        end
        checkOutput("fill16_no_stall", 16'(ok16), 16'd16);
        applyStimulus(BASE + 16'd2, READ, 16'h0000, lat);
        checkOutput("status_full", bus_if.rd_data, 16'h1006);
        applyStimulus(BASE, WRITE_B, 16'h005A, lat17);
        checkOutput("write17_stalled", 16'(lat17 > 1), 16'h0001);
        waitIdle();

        // Reset during DATA of an all-zero byte with 5 more queued.
        applyStimulus(BASE, WRITE, 16'h0000, lat);
        for (int i = 0; i < 5; i++) applyStimulus(BASE, WRITE, 16'(8'hC0 + i), lat);
        repeat (2) @(negedge clk);
        bus_if.addr = BASE + 16'd2;
        bus_if.cmd  = READ;
        checkOutput("pre_reset_low", 16'(uart_txp), 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_line_high", 16'(uart_txp), 16'h0001);
        reset = 1'b0;
        waitDone(lat);
        applyStimulus(BASE + 16'd2, READ, 16'h0000, lat);
        checkOutput("status_after_reset", bus_if.rd_data, 16'h0001);
        repeat (3 * FRAME) @(negedge clk);
        checkOutput("no_frames_after_reset", 16'(tx_idle), 16'h0001);

        // Two queued bytes go out back to back.
        applyStimulus(BASE, WRITE, 16'h00FF, lat);
        applyStimulus(BASE, WRITE, 16'h00FF, lat);
        for (int j = 0; j < FRAME + 2; j++) begin
            @(negedge clk);
            rec[j] = uart_txp;
        end
        checkOutput("chain_stop",  16'(rec[FRAME-3]), 16'h0001);
        checkOutput("chain_start", 16'(rec[FRAME-2]), 16'h0000);
        waitIdle();

        // Randomized traffic with occasional gaps and resets.
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                doReset($urandom_range(1, 3));
            end else if (r < 12) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
            end else begin
                r = $urandom_range(0, 9);
                if (r < 5)      ra = BASE;
                else if (r < 6) ra = BASE + 16'd1;
                else if (r < 8) ra = BASE + 16'd2;
                else if (r < 9) ra = BASE + 16'd3;
                else            ra = 16'($urandom_range(0, 65535));
                rc = bus_cmd_t'($urandom_range(0, 3));
                applyStimulus(ra, rc, 16'($urandom_range(0, 65535)), lat);
            end
        end
        waitIdle();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
